// File: rtl/rr_packet_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_packet_arbiter
//  Description : Packet-granular round-robin arbiter for one NoC router output
//                port shared by five inputs (local, west, east, north, south).
//                A winning input owns the port for PKT_LEN flits. The output
//                flit is registered with full-throughput valid/ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_packet_arbiter #(
  parameter logic [0:4] INPUT_MASK = 5'b11111, // element i enables input i
  parameter int         PKT_LEN    = 4,        // flits per packet, >= 1
  parameter int         DW         = 32        // router-wide flit width
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [DW-1:0] data_i [5],
  input  logic [4:0]    valid_i,
  output logic [4:0]    ready_o,
  output logic [DW-1:0] data_o,
  output logic          valid_o,
  input  logic          ready_i,
  output logic [4:0]    grant_o,
  output logic          busy_o
);

  localparam int            CW       = $clog2(PKT_LEN + 1);
  localparam logic [0:0]    IDLE     = 1'b0;
  localparam logic [0:0]    BUSY     = 1'b1;
  localparam logic [CW-1:0] TAIL_CNT = CW'(PKT_LEN - 1);

  logic [0:0]    state_q, state_d;
  logic [2:0]    ptr_q, ptr_d;
  logic [2:0]    owner_q, owner_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    grant_q, grant_d;
  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;

  logic [4:0]    mask;
  logic [4:0]    cand;
  logic          win_found;
  logic [2:0]    win_idx;
  logic [2:0]    sel_idx;
  logic          sel_ok;
  logic          load;
  logic          xfer;
  logic [DW-1:0] sel_data;
  int            j;

  // Re-order the mask so that bit i of the vector always means input i
  for (genvar gi = 0; gi < 5; gi++) begin : g_mask
    assign mask[gi] = INPUT_MASK[gi];
  end

  // Round-robin search starting just after the last packet owner
  always_comb begin
    cand      = valid_i & mask;
    win_found = 1'b0;
    win_idx   = 3'd0;
    j         = 0;
    for (int k = 1; k <= 5; k++) begin
      j = int'(ptr_q) + k;
      if (j >= 5) j = j - 5;
      if (!win_found && cand[3'(j)]) begin
        win_found = 1'b1;
        win_idx   = 3'(j);
      end
    end
  end

  // Handshake: only the selected input may see ready, and only when the output register can load
  always_comb begin
    load     = ~valid_q | ready_i;
    sel_idx  = (state_q == BUSY) ? owner_q : win_idx;
    sel_ok   = (state_q == BUSY) | win_found;
    ready_o  = (rstn && load && sel_ok) ? (5'b00001 << sel_idx) : 5'b00000;
    xfer     = |(valid_i & ready_o);
    sel_data = '0;
    for (int i = 0; i < 5; i++) begin
      if (sel_idx == 3'(i)) sel_data = data_i[i];
    end
  end

  // Next-state: output register and packet ownership tracking
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    valid_d = valid_q;
    data_d  = data_q;

    if (xfer) begin
      valid_d = 1'b1;
      data_d  = sel_data;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (xfer) begin
          if (PKT_LEN == 1) begin
            // Single-flit packets: the head is also the tail
            ptr_d = win_idx;
          end else begin
            state_d = BUSY;
            owner_d = win_idx;
            cnt_d   = CW'(1);
            grant_d = 5'b00001 << win_idx;
          end
        end
      end
      BUSY: begin
        if (xfer) begin
          if (cnt_q == TAIL_CNT) begin
            state_d = IDLE;
            ptr_d   = owner_q;
            cnt_d   = '0;
            grant_d = 5'b00000;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset drops any in-flight flit and restarts priority at input 0
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      ptr_q   <= 3'd4;
      owner_q <= 3'd0;
      cnt_q   <= '0;
      grant_q <= 5'b00000;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign grant_o = grant_q;
  assign busy_o  = (state_q == BUSY);

endmodule
`default_nettype wire

// File: tb/tb_rr_packet_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rr_packet_arbiter
//  Description : Self-checking bench for rr_packet_arbiter. Two instances share
//                the stimulus: u_dut0 with all inputs enabled and u_dut1 with
//                inputs 0 and 3 masked off. A packet-level model is compared
//                against both on every cycle; directed sections add literals.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_packet_arbiter;

  localparam int PKT_LEN = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] data_i [5];
  logic [4:0]  valid_i;
  logic        ready_i;

  logic [4:0]  rdy  [2];
  logic [31:0] dout [2];
  logic        vout [2];
  logic [4:0]  gnt  [2];
  logic        bsy  [2];

  logic [15:0] data_hi [5];
  logic [15:0] seq     [5];

  // bit i = input i may be granted
  logic [4:0]  en_mask [2];

  int errors = 0;
  int checks = 0;

  // model state per instance
  int          m_busy  [2];
  int          m_owner [2];
  int          m_ptr   [2];
  int          m_sent  [2];
  logic        m_vo    [2];
  logic [31:0] m_do    [2];

  logic [31:0] out_q[$];
  logic [4:0]  seen1;
  logic [4:0]  bad1;

  always #5 clk = ~clk;

  rr_packet_arbiter #(.INPUT_MASK(5'b11111), .PKT_LEN(PKT_LEN), .DW(32)) u_dut0 (
    .clk(clk), .rstn(rstn), .data_i(data_i), .valid_i(valid_i), .ready_o(rdy[0]),
    .data_o(dout[0]), .valid_o(vout[0]), .ready_i(ready_i), .grant_o(gnt[0]), .busy_o(bsy[0])
  );

  rr_packet_arbiter #(.INPUT_MASK(5'b01101), .PKT_LEN(PKT_LEN), .DW(32)) u_dut1 (
    .clk(clk), .rstn(rstn), .data_i(data_i), .valid_i(valid_i), .ready_o(rdy[1]),
    .data_o(dout[1]), .valid_o(vout[1]), .ready_i(ready_i), .grant_o(gnt[1]), .busy_o(bsy[1])
  );

  // Flit payload = {source tag, per-input sequence number}
  always_comb begin
    for (int i = 0; i < 5; i++) data_i[i] = {data_hi[i], seq[i]};
  end

  // Each input advances to its next flit when u_dut0 accepts the current one
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 5; i++) seq[i] <= 16'd1;
    end else begin
      for (int i = 0; i < 5; i++)
        if (valid_i[i] && rdy[0][i]) seq[i] <= seq[i] + 16'd1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Packet-level model: who should own the port, what the outputs must show
  task automatic model_step(input int n);
    int          sel;
    int          jj;
    logic        ld;
    logic        xf;
    logic [4:0]  exp_rdy;
    logic [4:0]  exp_gnt;
    if (!rstn) begin
      m_busy[n] = 0; m_ptr[n] = 4; m_sent[n] = 0; m_owner[n] = 0;
      m_vo[n] = 1'b0; m_do[n] = 32'd0;
    end
    ld  = !m_vo[n] || ready_i;
    sel = -1;
    if (m_busy[n] != 0) begin
      sel = m_owner[n];
    end else begin
      for (int k = 1; k <= 5; k++) begin
        jj = (m_ptr[n] + k) % 5;
        if (sel < 0 && valid_i[jj] && en_mask[n][jj]) sel = jj;
      end
    end
    exp_rdy = (rstn && ld && sel >= 0) ? 5'(1 << sel) : 5'b00000;
    exp_gnt = (m_busy[n] != 0) ? 5'(1 << m_owner[n]) : 5'b00000;

    check($sformatf("u%0d ready_o", n), 32'(rdy[n]), 32'(exp_rdy));
    check($sformatf("u%0d valid_o", n), 32'(vout[n]), 32'(m_vo[n]));
    check($sformatf("u%0d data_o", n), dout[n], m_do[n]);
    check($sformatf("u%0d grant_o", n), 32'(gnt[n]), 32'(exp_gnt));
    check($sformatf("u%0d busy_o", n), 32'(bsy[n]), 32'(m_busy[n] != 0));

    if (rstn) begin
      xf = (sel >= 0) && ld && valid_i[sel];
      if (xf) begin
        m_vo[n] = 1'b1;
        m_do[n] = data_i[sel];
      end else if (ready_i) begin
        m_vo[n] = 1'b0;
      end
      if (xf) begin
        if (m_busy[n] != 0) begin
          m_sent[n]++;
          if (m_sent[n] == PKT_LEN) begin
            m_busy[n] = 0; m_ptr[n] = m_owner[n]; m_sent[n] = 0;
          end
        end else if (PKT_LEN == 1) begin
          m_ptr[n] = sel;
        end else begin
          m_busy[n] = 1; m_owner[n] = sel; m_sent[n] = 1;
        end
      end
    end
  endtask

  // Per-cycle comparison, sampled on the falling edge
  always @(negedge clk) begin
    if (rstn && vout[0] && ready_i) out_q.push_back(dout[0]);
    if (rstn) begin
      seen1 <= seen1 | gnt[1];
      bad1  <= bad1 | (rdy[1] & 5'b01001);
    end
    for (int n = 0; n < 2; n++) model_step(n);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rstn    = 1'b0;
    valid_i = 5'b00000;
    ready_i = 1'b1;
    tick();
    tick();
    rstn = 1'b1;
    out_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [15:0] t2_src [12];
    logic [15:0] t2_seq [12];
    t2_src = '{16'd1, 16'd1, 16'd1, 16'd1, 16'd3, 16'd3, 16'd3, 16'd3, 16'd4, 16'd4, 16'd4, 16'd4};
    t2_seq = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd1, 16'd2, 16'd3, 16'd4, 16'd1, 16'd2, 16'd3, 16'd4};
    en_mask[0] = 5'b11111;
    en_mask[1] = 5'b10110;
    for (int i = 0; i < 5; i++) data_hi[i] = 16'(i);
    seen1   = 5'b00000;
    bad1    = 5'b00000;
    rstn    = 1'b0;
    valid_i = 5'b00000;
    ready_i = 1'b1;

    // 1: reset holds everything quiet even with all inputs requesting
    valid_i = 5'b11111;
    tick();
    tick();
    check("t1 reset ready_o", 32'(rdy[0]), 32'h0);
    check("t1 reset valid_o", 32'(vout[0]), 32'h0);
    check("t1 reset grant_o", 32'(gnt[0]), 32'h0);
    rstn = 1'b1;
    #1;
    check("t1 first ready", 32'(rdy[0]), 32'h1);
    tick();
    check("t1 first grant", 32'(gnt[0]), 32'h1);
    check("t1 first flit", dout[0], 32'h0000_0001);

    // 2: fairness across inputs 1,3,4 with back-to-back packets
    do_reset();
    valid_i = 5'b11010;
    tick();
    for (int k = 0; k < 12; k++) begin
      check($sformatf("t2 valid %0d", k), 32'(vout[0]), 32'h1);
      check($sformatf("t2 flit %0d", k), dout[0], {t2_src[k], t2_seq[k]});
      tick();
    end

    // 3: owner 2 stalls mid-packet; input 0 must wait
    do_reset();
    valid_i = 5'b00100;
    tick();
    tick();
    valid_i = 5'b00001;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("t3 busy %0d", k), 32'(bsy[0]), 32'h1);
      check($sformatf("t3 ready %0d", k), 32'(rdy[0]), 32'h4);
      check($sformatf("t3 grant %0d", k), 32'(gnt[0]), 32'h4);
      tick();
    end
    valid_i = 5'b00101;
    for (int k = 0; k < 4; k++) tick();
    @(negedge clk);
    #1;
    check("t3 flit count", 32'(out_q.size() >= 6), 32'h1);
    if (out_q.size() >= 6) begin
      check("t3 seq 0", out_q[0], 32'h0002_0001);
      check("t3 seq 1", out_q[1], 32'h0002_0002);
      check("t3 seq 2", out_q[2], 32'h0002_0003);
      check("t3 seq 3", out_q[3], 32'h0002_0004);
      check("t3 seq 4", out_q[4], 32'h0000_0001);
      check("t3 seq 5", out_q[5], 32'h0000_0002);
    end

    // 4: downstream backpressure freezes the port
    do_reset();
    data_hi[0] = 16'hA5A5;
    valid_i = 5'b00001;
    tick();
    ready_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("t4 hold data %0d", k), dout[0], 32'hA5A5_0001);
      check($sformatf("t4 hold valid %0d", k), 32'(vout[0]), 32'h1);
      check($sformatf("t4 hold ready %0d", k), 32'(rdy[0]), 32'h0);
      tick();
    end
    ready_i = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    @(negedge clk);
    #1;
    check("t4 flit count", 32'(out_q.size() >= 5), 32'h1);
    if (out_q.size() >= 5) begin
      for (int k = 0; k < 5; k++)
        check($sformatf("t4 seq %0d", k), out_q[k], {16'hA5A5, 16'(k + 1)});
    end
    data_hi[0] = 16'd0;

    // 5: masked instance only ever serves inputs 1, 2 and 4
    do_reset();
    seen1   = 5'b00000;
    bad1    = 5'b00000;
    valid_i = 5'b11111;
    for (int k = 0; k < 40; k++) tick();
    @(negedge clk);
    #1;
    check("t5 granted set", 32'(seen1), 32'h16);
    check("t5 masked ready", 32'(bad1), 32'h0);

    // 6: reset in the middle of a packet
    do_reset();
    valid_i = 5'b00001;
    tick();
    tick();
    rstn = 1'b0;
    #1;
    check("t6 valid at reset", 32'(vout[0]), 32'h0);
    check("t6 busy at reset", 32'(bsy[0]), 32'h0);
    check("t6 grant at reset", 32'(gnt[0]), 32'h0);
    tick();
    valid_i = 5'b11111;
    rstn = 1'b1;
    #1;
    check("t6 restart ready", 32'(rdy[0]), 32'h1);
    tick();
    check("t6 restart grant", 32'(gnt[0]), 32'h1);
    check("t6 restart flit", dout[0], 32'h0000_0001);

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
